muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M operations of the EX stage: latches operands on START, sequences a registered multiply or a 32-iteration restoring divide, and raises BUSY so the hazard unit stalls IF/ID/EX.
- Resolves RISC-V divide-by-zero and signed-overflow cases without iterating.
- Returns one RESULT with a single-cycle VALID pulse; the main ALU keeps all single-cycle RV32I ops.

Parameters:
- MUL_CYCLES, 2, cycles from START acceptance to VALID for MUL/MULH/MULHSU/MULHU; legal range 1..4.
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request from EX; sampled only when BUSY=0.
- SELECT  input  5  op code: 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- DATA1  input  32  rs1 / dividend / multiplicand.
- DATA2  input  32  rs2 / divisor / multiplier.
- FLUSH  input  1  branch-mispredict kill; aborts any op in flight.
- BUSY  output  1  high from the cycle after acceptance until the cycle VALID is high, inclusive; drives the pipeline stall.
- VALID  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  32  result register.

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE, BUSY=0, VALID=0, RESULT=0, all iteration registers=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Acceptance: START=1, BUSY=0, FLUSH=0 and SELECT[4:3]=01 at a rising edge. The block latches SELECT, DATA1 and DATA2. Any other START is ignored: no BUSY, no VALID.
- IDLE->MUL (SELECT[2]=0):
  - Signedness: MUL/MULH use signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Form the 64-bit product from 33-bit extended operands. MUL returns product[31:0]; the others return product[63:32].
  - Countdown from MUL_CYCLES-1, then DONE. VALID is high exactly MUL_CYCLES cycles after the acceptance edge.
- IDLE->DONE (special divides, SELECT[2]=1):
  - Divisor==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return DATA1.
  - DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
  - VALID is high 1 cycle after acceptance.
- IDLE->DIV (normal divides):
  - Signed ops convert both operands to magnitudes. Record quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - 32 iterations, one quotient bit per cycle, MSB first. Each iteration shifts the remainder left with the next dividend bit, subtracts the divisor if there is no borrow, and shifts the quotient bit in.
  - A 6-bit counter runs 0..31, then the state moves to FIX.
- FIX: negate quotient/remainder per the recorded signs and select quotient (DIV/DIVU) or remainder (REM/REMU). Next state is DONE. VALID is high 34 cycles after acceptance.
- DONE: VALID=1, BUSY=1, RESULT updated. Next state is IDLE; VALID drops the following cycle.
- Back-to-back operation: a new START is accepted in the cycle after DONE (BUSY=0). START during DONE is ignored; EX holds it because of the stall.
- RESULT holds its last value until the next DONE and is never cleared except by reset.
- FLUSH:
  - Asserted in MUL/DIV/FIX/DONE: synchronous return to IDLE next edge, BUSY=0, no VALID. If FLUSH coincides with DONE, VALID is still suppressed and RESULT is not updated.
  - FLUSH and START in the same IDLE cycle: FLUSH wins and nothing is accepted.
- RESET_N low mid-operation: immediate IDLE with all outputs at reset values. The first START after release behaves normally.
- Operand changes while BUSY=1 have no effect (operands are latched).

Test Plan:
- MULH, DATA1=0xFFFFFFFE (-2), DATA2=0x00000003, MUL_CYCLES=2 -> VALID 2 cycles after accept, RESULT=0xFFFFFFFF; MUL of the same operands gives 0xFFFFFFFA.
- DIV, DATA1=0xFFFFFFF9 (-7), DATA2=0x00000002 -> BUSY for 34 cycles, RESULT=0xFFFFFFFD (-3); REM of the same operands gives 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC.
- DIVU, DATA1=0x12345678, DATA2=0 -> VALID 1 cycle after accept, RESULT=0xFFFFFFFF; REMU of the same operands gives 0x12345678.
- DIV, DATA1=0x80000000, DATA2=0xFFFFFFFF -> 1-cycle result 0x80000000; REM of the same operands gives 0x00000000.
- Start DIV 100/7, assert FLUSH at iteration 10 -> BUSY=0 next cycle, no VALID, RESULT unchanged. Then REMU 100/7 -> RESULT=0x00000002.
- Pull RESET_N low mid-DIV (asynchronous, between edges) -> BUSY, VALID and RESULT go to 0 immediately. START with SELECT=00000 (ADD) -> ignored, BUSY stays 0.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_if;
  logic        start;
  logic [4:0]  select;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (output start, select, data1, data2, flush, input busy, valid, result);
  modport slave  (input start, select, data1, data2, flush, output busy, valid, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: registered multiply, 32-step restoring divide,
// single-cycle resolution of divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int XLEN       = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [5:0]      MUL_LOAD = (MUL_CYCLES > 1) ? 6'(MUL_CYCLES - 2) : 6'd0;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic [1:0]      op_reg;
  logic [XLEN-1:0] a_reg, b_reg, quo_reg, rem_reg, div_reg, stage_reg, result_reg;
  logic            q_neg_reg, r_neg_reg;
  logic [5:0]      cnt_reg;

  logic            accept, in_idle, is_signed, div_zero, div_ovf, div_special, no_borrow;
  logic [1:0]      mul_op;
  logic [XLEN-1:0] mul_a, mul_b, mag1, mag2, special_res, mul_res, fix_res;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, product;
  logic [XLEN:0]   shifted;

  always_comb begin
    in_idle     = (state_reg == S_IDLE);
    accept      = in_idle && bus.start && !bus.flush && (bus.select[4:3] == 2'b01);
    is_signed   = !bus.select[0];
    div_zero    = (bus.data2 == '0);
    div_ovf     = is_signed && (bus.data1 == INT_MIN) && (bus.data2 == '1);
    div_special = div_zero || div_ovf;
    if (div_zero)
      special_res = bus.select[1] ? bus.data1 : '1;
    else
      special_res = bus.select[1] ? '0 : INT_MIN;
    mag1 = (is_signed && bus.data1[XLEN-1]) ? -bus.data1 : bus.data1;
    mag2 = (is_signed && bus.data2[XLEN-1]) ? -bus.data2 : bus.data2;

    // Multiplier reads the live operands in IDLE so MUL_CYCLES=1 can finish on the accept edge.
    mul_op    = in_idle ? bus.select[1:0] : op_reg;
    mul_a     = in_idle ? bus.data1 : a_reg;
    mul_b     = in_idle ? bus.data2 : b_reg;
    mul_a_ext = {{XLEN{(mul_op != 2'b11) && mul_a[XLEN-1]}}, mul_a};
    mul_b_ext = {{XLEN{!mul_op[1] && mul_b[XLEN-1]}}, mul_b};
    product   = mul_a_ext * mul_b_ext;
    mul_res   = (mul_op == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    shifted   = {rem_reg, quo_reg[XLEN-1]};
    no_borrow = (shifted >= {1'b0, div_reg});
    fix_res   = op_reg[1] ? (r_neg_reg ? -rem_reg : rem_reg)
                          : (q_neg_reg ? -quo_reg : quo_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (!bus.select[2])
            state_next = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
          else
            state_next = div_special ? S_DONE : S_DIV;
        end
      end
      S_MUL:  state_next = bus.flush ? S_IDLE : ((cnt_reg == 6'd0) ? S_DONE : S_MUL);
      S_DIV:  state_next = bus.flush ? S_IDLE : ((cnt_reg == 6'd31) ? S_FIX : S_DIV);
      S_FIX:  state_next = bus.flush ? S_IDLE : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      div_reg    <= '0;
      stage_reg  <= '0;
      result_reg <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= bus.select[1:0];
            a_reg     <= bus.data1;
            b_reg     <= bus.data2;
            cnt_reg   <= bus.select[2] ? 6'd0 : MUL_LOAD;
            stage_reg <= bus.select[2] ? special_res : mul_res;
            quo_reg   <= mag1;
            div_reg   <= mag2;
            rem_reg   <= '0;
            q_neg_reg <= is_signed && (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]);
            r_neg_reg <= is_signed && bus.data1[XLEN-1];
          end
        end
        S_MUL: begin
          stage_reg <= mul_res;
          if (cnt_reg != 6'd0)
            cnt_reg <= cnt_reg - 6'd1;
        end
        S_DIV: begin
          // quo_reg doubles as the dividend shift register; quotient bits enter at the LSB.
          rem_reg <= no_borrow ? XLEN'(shifted - {1'b0, div_reg}) : shifted[XLEN-1:0];
          quo_reg <= {quo_reg[XLEN-2:0], no_borrow};
          cnt_reg <= cnt_reg + 6'd1;
        end
        S_FIX:  stage_reg <= fix_res;
        S_DONE: begin
          if (!bus.flush)
            result_reg <= stage_reg;
        end
        default: ;
      endcase
    end
  end

  // A flush landing on DONE must hide the fresh value, so RESULT bypasses only while VALID is shown.
  assign bus.busy   = (state_reg != S_IDLE);
  assign bus.valid  = (state_reg == S_DONE) && !bus.flush;
  assign bus.result = bus.valid ? stage_reg : result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed RV32M cases plus randomized traffic against a latency/arithmetic model.
module tb_muldiv_sequencer;
  localparam int MUL_CYCLES = 2;

  logic clk;
  logic rst_n;
  muldiv_if bus();

  muldiv_sequencer #(.MUL_CYCLES(MUL_CYCLES), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          left = 0;
  logic [31:0] pend = '0;
  logic [31:0] committed = '0;
  logic        exp_valid, exp_busy;
  logic [31:0] exp_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb;
    sa = signed'(a);
    sb = signed'(b);
    p  = 0;
    case (sel[2:0])
      3'd0, 3'd1: p = longint'(sa) * longint'(sb);
      3'd2:       p = longint'(sa) * longint'({32'b0, b});
      3'd3:       p = longint'({32'b0, a}) * longint'({32'b0, b});
      default:    p = 0;
    endcase
    case (sel[2:0])
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (!sel[2]) return MUL_CYCLES;
    if (b == 0 || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Model: 'left' counts the busy cycles still owed; VALID falls in the last one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        left      = 0;
        committed = '0;
      end
      exp_busy  = (left > 0);
      exp_valid = (left == 1) && !bus.flush;
      exp_res   = exp_valid ? pend : committed;
      check("busy",   32'(bus.busy),  32'(exp_busy));
      check("valid",  32'(bus.valid), 32'(exp_valid));
      check("result", bus.result,     exp_res);
      if (rst_n) begin
        if (left == 0) begin
          if (bus.start && !bus.flush && bus.select[4:3] == 2'b01) begin
            left = latency(bus.select, bus.data1, bus.data2);
            pend = ref_res(bus.select, bus.data1, bus.data2);
          end
        end else if (bus.flush) begin
          left = 0;
        end else begin
          if (left == 1) committed = pend;
          left--;
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp);
    int n;
    bus.start = 1'b1; bus.select = sel; bus.data1 = a; bus.data2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.select = 5'($urandom); bus.data1 = $urandom; bus.data2 = $urandom;
    n = 1;
    @(negedge clk);
    while (!bus.valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, bus.result, exp);
    $display("op %s sel=%05b a=0x%08h b=0x%08h -> 0x%08h after %0d cycles", name, sel, a, b, bus.result, n);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int hits;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.select = '0; bus.data1 = '0; bus.data2 = '0; bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   32'(bus.busy),  32'h0);
    check("reset_valid",  32'(bus.valid), 32'h0);
    check("reset_result", bus.result,     32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mulh",     5'b01001, 32'hFFFF_FFFE, 32'h0000_0003, MUL_CYCLES, 32'hFFFF_FFFF);
    run_op("mul",      5'b01000, 32'hFFFF_FFFE, 32'h0000_0003, MUL_CYCLES, 32'hFFFF_FFFA);
    run_op("div",      5'b01100, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFD);
    run_op("rem",      5'b01110, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF);
    run_op("divu",     5'b01101, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'h7FFF_FFFC);
    run_op("divu_z",   5'b01101, 32'h1234_5678, 32'h0, 1, 32'hFFFF_FFFF);
    run_op("remu_z",   5'b01111, 32'h1234_5678, 32'h0, 1, 32'h1234_5678);
    run_op("div_ovf",  5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf",  5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
    run_op("divu_pre", 5'b01101, 32'd1000, 32'd3, 34, 32'h0000_014D);

    // Kill a DIV at iteration 10.
    bus.start = 1'b1; bus.select = 5'b01100; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy",   32'(bus.busy), 32'h0);
    check("flush_result", bus.result,    32'h0000_014D);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) hits++;
    end
    check("flush_no_valid", 32'(hits), 32'h0);
    @(posedge clk); #1;
    run_op("remu", 5'b01111, 32'd100, 32'd7, 34, 32'h0000_0002);

    // Flush landing on the DONE cycle.
    bus.start = 1'b1; bus.select = 5'b01000; bus.data1 = 32'd6; bus.data2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("done_flush_valid",  32'(bus.valid), 32'h0);
    check("done_flush_result", bus.result,     32'h0000_0002);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("done_flush_busy", 32'(bus.busy), 32'h0);

    // FLUSH beats START in IDLE.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.select = 5'b01000;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 32'(bus.busy), 32'h0);

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.select = 5'b01100; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(bus.busy),  32'h0);
    check("arst_valid",  32'(bus.valid), 32'h0);
    check("arst_result", bus.result,     32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b1; bus.select = 5'b00000; bus.data1 = 32'd5; bus.data2 = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("add_ignored", 32'(bus.busy), 32'h0);
    @(posedge clk); #1;
    run_op("mulhu", 5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYCLES, 32'hFFFF_FFFE);
    run_op("mulhsu", 5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYCLES, 32'hFFFF_FFFF);

    // Random traffic: the per-cycle model does all the checking here.
    for (int i = 0; i < 3000; i++) begin
      bus.start  = ($urandom_range(0, 2) != 0);
      bus.select = ($urandom_range(0, 7) == 0) ? 5'($urandom) : {2'b01, 3'($urandom)};
      bus.data1  = pick();
      bus.data2  = pick();
      bus.flush  = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
